sum_recover_sub: RTL and testbench
==================================

Name: sum_recover_sub

Overview:
- Pipelined, handshaked inverse of the team's combinational 16-bit adder.
- Accepts a (width+1)-bit sum and one width-bit addend; returns the other addend `a = sum - b`, plus an underflow flag and an out-of-range flag.
- Two-stage split subtractor: low half in stage 1, high half plus borrow in stage 2.
- Sits downstream of the adder datapath for operand recovery and checking; sustains one result per cycle.

Parameters:
- width, 16, operand width; `sum` is width+1 bits. Must be even and ≥ 2.
- LO, width/2, bit count of the low half handled in stage 1 (derived, not overridable).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; 0 freezes the block
- in_valid  input  1  sum/b present
- in_ready  output  1  block accepts sum/b this cycle
- sum  input  width+1  minuend (adder output format)
- b  input  width  subtrahend (known addend)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- a  output  width  recovered addend, `(sum - b) mod 2^width`
- underflow  output  1  `sum < b`
- range_err  output  1  `sum - b ≥ 2^width` (result does not fit width bits)

Behaviour:
- Reset (rst=1 at edge):
  - s1_valid=0, s2_valid=0.
  - a=0, underflow=0, range_err=0.
  - out_valid=0 and in_ready=0 during the reset cycle.
  - Reset dominates en and all handshakes; in-flight data is discarded, never emitted.
- Arithmetic:
  - `diff = {1'b0,sum} - {2'b0,b}`, computed in width+2 bits.
  - `underflow = diff[width+1]`.
  - `range_err = !underflow && diff[width]`.
  - `a = diff[width-1:0]`.
  - underflow and range_err are mutually exclusive.
- Stage 1 (on input accept):
  - Registers `lo_diff = sum[LO-1:0] - b[LO-1:0]` and its borrow-out.
  - Registers `sum[width:LO]` and `b[width-1:LO]`.
- Stage 2:
  - `hi_diff = {1'b0,sum_hi} - {1'b0,b_hi} - borrow`.
  - Registers a, underflow and range_err derived from `{hi_diff, lo_diff}`.
- Combined result must be bit-identical to the single-subtract definition above for all inputs.
- Handshake, all conditioned on en=1 and rst=0:
  - `adv2 = !s2_valid || out_ready`
  - `adv1 = !s1_valid || adv2`
  - `in_ready = en && !rst && adv1`
  - `out_valid = en && s2_valid`
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
- Stall: while `s2_valid && !out_ready`, a/underflow/range_err hold stable and stage 1 holds if occupied. No data is lost or duplicated.
- Latency and throughput:
  - Accept at edge N → out_valid high from cycle after edge N+1 (2-cycle latency) when unstalled.
  - Back-to-back accepts give back-to-back results.
- Same-cycle events:
  - Output transfer and input transfer in the same cycle are legal at full occupancy. Pipeline shifts and stays full.
  - Bubbles collapse: stage 1 fills stage 2 when s2 is empty, regardless of out_ready.
- en=0:
  - No register changes; in_ready=0, out_valid=0.
  - out_ready is ignored; no transfer occurs.
  - On en returning to 1, state resumes exactly.
- Result fields are don't-care while out_valid=0, except after reset, when they read 0.

Test Plan:
- Reset, then sum=0x10005, b=0x0006, out_ready=1 → 2 cycles after accept: a=0xFFFF, underflow=0, range_err=0.
- Borrow across halves: sum=0x00100, b=0x0001 → a=0x00FF, both flags 0.
- Boundaries:
  - sum=0x00003, b=0x0004 → a=0xFFFF, underflow=1, range_err=0.
  - sum=0x1FFFF, b=0x0000 → a=0xFFFF, underflow=0, range_err=1.
  - sum=0x10000, b=0x0000 → a=0x0000, range_err=1.
- Stream of 20 random pairs with in_valid always 1 and out_ready toggled pseudo-randomly:
  - Outputs match the reference model, in order, with no loss or duplication.
  - a is stable while out_valid && !out_ready.
  - in_ready drops only when both stages are full and out_ready=0.
- en=0 for 5 cycles with both stages full and out_ready=1 → no transfers, in_ready=0, out_valid=0. After en=1, the two pending results emit unchanged on consecutive cycles.
- rst pulsed for one cycle with both stages full → next cycle out_valid=0, a=0, flags 0. A subsequent single accept yields exactly one result 2 cycles later.

Source files
------------

// File: rtl/sum_recover_sub_if.sv
// Handshaked operand bundle for sum_recover_sub: sum/b in, recovered addend and flags out.
// A transfer happens on a side only in a cycle where both its valid and ready are high.
interface sum_recover_sub_if #(
  parameter int width = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [width:0]   sum;
  logic [width-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] a;
  logic             underflow;
  logic             range_err;

  modport master (
    output in_valid, sum, b, out_ready,
    input  in_ready, out_valid, a, underflow, range_err
  );

  modport slave (
    input  in_valid, sum, b, out_ready,
    output in_ready, out_valid, a, underflow, range_err
  );
endinterface

// File: rtl/sum_recover_sub.sv
// Two-stage split subtractor recovering a = sum - b from an adder result:
// low half and its borrow in stage 1, high half with borrow and the flags in stage 2.
module sum_recover_sub #(
  parameter int width = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  sum_recover_sub_if.slave    io
);
  localparam int LO = width / 2;

  logic             s1_valid_q;
  logic [LO-1:0]    lo_diff_q;
  logic             borrow_q;
  logic [LO:0]      sum_hi_q;
  logic [LO-1:0]    b_hi_q;

  logic             s2_valid_q;
  logic [width-1:0] a_q;
  logic             underflow_q;
  logic             range_err_q;

  logic             adv1;
  logic             adv2;
  logic             in_ready;
  logic             accept;
  logic [LO:0]      lo_full;
  logic [LO+1:0]    hi_diff;
  logic [width-1:0] a_d;
  logic             underflow_d;
  logic             range_err_d;

  always_comb begin
    adv2     = !s2_valid_q || io.out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = en && !rst && adv1;
    accept   = io.in_valid && in_ready;
    lo_full  = {1'b0, io.sum[LO-1:0]} - {1'b0, io.b[LO-1:0]};
    // hi_diff concatenated above lo_diff reproduces the full (width+2)-bit difference
    hi_diff  = {1'b0, sum_hi_q} - {2'b00, b_hi_q} - {{(LO+1){1'b0}}, borrow_q};
    a_d         = {hi_diff[LO-1:0], lo_diff_q};
    underflow_d = hi_diff[LO+1];
    range_err_d = !hi_diff[LO+1] && hi_diff[LO];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_diff_q   <= '0;
      borrow_q    <= 1'b0;
      sum_hi_q    <= '0;
      b_hi_q      <= '0;
      s2_valid_q  <= 1'b0;
      a_q         <= '0;
      underflow_q <= 1'b0;
      range_err_q <= 1'b0;
    end else if (en) begin
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          lo_diff_q <= lo_full[LO-1:0];
          borrow_q  <= lo_full[LO];
          sum_hi_q  <= io.sum[width:LO];
          b_hi_q    <= io.b[width-1:LO];
        end
      end
      // Result registers only move when a valid stage-1 entry is promoted
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          a_q         <= a_d;
          underflow_q <= underflow_d;
          range_err_q <= range_err_d;
        end
      end
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = en && !rst && s2_valid_q;
  assign io.a         = a_q;
  assign io.underflow = underflow_q;
  assign io.range_err = range_err_q;
endmodule

// File: tb/tb_sum_recover_sub.sv
// Bench for sum_recover_sub: directed boundary cases, a randomized stalled stream,
// an enable freeze and a mid-flight reset, all scored against an arithmetic model.
module tb_sum_recover_sub;
  localparam int W = 16;

  logic clk;
  logic rst;
  logic en;
  int   n_checks;
  int   n_errors;
  int   n_out;

  sum_recover_sub_if #(.width(W)) io ();

  sum_recover_sub #(.width(W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer subtraction, result packed as {underflow, range_err, a}
  function automatic logic [W+1:0] model(input logic [W:0] s, input logic [W-1:0] bb);
    int d;
    logic [W-1:0] av;
    d  = int'(s) - int'(bb);
    av = d[W-1:0];
    return {d < 0, d >= (1 << W), av};
  endfunction

  logic [W+1:0] exp_q[$];
  logic         prev_stall;
  logic [W+1:0] prev_res;

  // Scoreboard/monitor sampled on the falling edge, between driver updates
  always @(negedge clk) begin
    logic [W+1:0] got;
    logic [W+1:0] e;
    logic         exp_rdy;
    got     = {io.underflow, io.range_err, io.a};
    exp_rdy = en && !rst && !(exp_q.size() == 2 && !io.out_ready);
    check("in_ready", {31'd0, io.in_ready}, {31'd0, exp_rdy});
    if (!en || rst) check("out_valid_off", {31'd0, io.out_valid}, 32'd0);
    if (prev_stall && io.out_valid) check("stall_hold", {14'd0, got}, {14'd0, prev_res});
    prev_stall = io.out_valid && !io.out_ready;
    prev_res   = got;
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {14'd0, got}, {14'd0, e});
        n_out++;
      end
    end
    if (io.in_valid && io.in_ready) exp_q.push_back(model(io.sum, io.b));
    if (rst) exp_q.delete();
  end

  task automatic directed(input string tag, input logic [W:0] s, input logic [W-1:0] bb,
                          input logic [W-1:0] ea, input logic eu, input logic er);
    @(posedge clk); #1;
    io.in_valid = 1'b1; io.sum = s; io.b = bb; io.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, io.in_ready}, 32'd1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {31'd0, io.out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_lat2"}, {31'd0, io.out_valid}, 32'd1);
    check({tag, "_a"}, {16'd0, io.a}, {16'd0, ea});
    check({tag, "_uf"}, {31'd0, io.underflow}, {31'd0, eu});
    check({tag, "_re"}, {31'd0, io.range_err}, {31'd0, er});
  endtask

  // Leaves both stages occupied with out_ready low
  task automatic fill_two();
    @(posedge clk); #1;
    io.out_ready = 1'b0; io.in_valid = 1'b1;
    io.sum = 17'($urandom_range(0, 17'h1FFFF)); io.b = 16'($urandom_range(0, 16'hFFFF));
    @(posedge clk); #1;
    io.sum = 17'($urandom_range(0, 17'h1FFFF)); io.b = 16'($urandom_range(0, 16'hFFFF));
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int cyc;
    int base;
    logic acc;
    n_checks = 0; n_errors = 0; n_out = 0;
    prev_stall = 1'b0; prev_res = '0;
    rst = 1'b1; en = 1'b1;
    io.in_valid = 1'b0; io.sum = '0; io.b = '0; io.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_a", {16'd0, io.a}, 32'd0);
    check("rst_flags", {30'd0, io.underflow, io.range_err}, 32'd0);
    check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);

    directed("basic",   17'h10005, 16'h0006, 16'hFFFF, 1'b0, 1'b0);
    directed("borrow",  17'h00100, 16'h0001, 16'h00FF, 1'b0, 1'b0);
    directed("under",   17'h00003, 16'h0004, 16'hFFFF, 1'b1, 1'b0);
    directed("rng_max", 17'h1FFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    directed("rng_min", 17'h10000, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Randomized stream: in_valid held high, out_ready toggling
    @(posedge clk); #1;
    io.in_valid = 1'b1;
    io.sum = 17'($urandom_range(0, 17'h1FFFF)); io.b = 16'($urandom_range(0, 16'hFFFF));
    sent = 0; cyc = 0;
    while (sent < 20 && cyc < 500) begin
      @(negedge clk);
      acc = io.in_ready;
      @(posedge clk); #1;
      cyc++;
      io.out_ready = 1'($urandom_range(0, 1));
      if (acc) begin
        sent++;
        if (sent == 20) io.in_valid = 1'b0;
        else begin
          io.sum = 17'($urandom_range(0, 17'h1FFFF)); io.b = 16'($urandom_range(0, 16'hFFFF));
        end
      end
    end
    check("stream_sent", sent, 20);
    io.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_drain", exp_q.size(), 0);

    // Enable freeze with both stages full
    fill_two();
    en = 1'b0; io.out_ready = 1'b1;
    base = n_out;
    repeat (5) @(posedge clk);
    #1;
    check("en_no_xfer", n_out - base, 0);
    check("en_pending", exp_q.size(), 2);
    en = 1'b1;
    @(negedge clk);
    check("en_res1_valid", {31'd0, io.out_valid}, 32'd1);
    @(negedge clk);
    check("en_res2_valid", {31'd0, io.out_valid}, 32'd1);
    @(negedge clk);
    check("en_empty", {31'd0, io.out_valid}, 32'd0);
    check("en_emitted", n_out - base, 2);

    // Reset with both stages full discards in-flight data
    fill_two();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; io.out_ready = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", {31'd0, io.out_valid}, 32'd0);
    check("rst2_a", {16'd0, io.a}, 32'd0);
    check("rst2_flags", {30'd0, io.underflow, io.range_err}, 32'd0);
    base = n_out;
    directed("post_rst", 17'h0ABCD, 16'h1234, 16'h9999, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_count", n_out - base, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
